// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and time constants for the stopwatch controller
//
// Contents:
//   sw_state_t : FSM state encoding (ST_IDLE/ST_RUN/ST_PAUSE/ST_LAP), also driven out for LEDs
//   TIME_W     : width of the packed BCD time word (hh:mm:ss.cc, 8 digits)
//   TIME_MAX   : 99:59:59.99, the saturation point of the counter chain
package stopwatch_pkg;

    localparam int TIME_W = 32;

    localparam logic [TIME_W-1:0] TIME_MAX = 32'h99595999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/tick/time inputs and counter/display outputs of stopwatch_ctrl
//
// Signals:
//   btn_ss, btn_lap : debounced single-cycle button pulses
//   tick_100hz      : 10 ms strobe from the clock divider
//   time_bcd        : live counter-chain value, digit 0 in LSBs
//   count_tick      : gated tick into the digit-0 counter
//   count_clr       : one-cycle synchronous clear to the counter chain
//   disp_bcd        : value for the display scanner
//   lap_num         : two-digit BCD lap index
//   disp_blank      : blank all digits while high
//   state           : FSM state for LEDs/debug
// Modports:
//   master : the surroundings (buttons, divider, counter chain, display)
//   slave  : the controller
interface stopwatch_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  btn_ss;
    logic                  btn_lap;
    logic                  tick_100hz;
    logic [4*DIGITS-1:0]   time_bcd;
    logic                  count_tick;
    logic                  count_clr;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic [7:0]            lap_num;
    logic                  disp_blank;
    logic [1:0]            state;

    modport master (
        output btn_ss, btn_lap, tick_100hz, time_bcd,
        input  count_tick, count_clr, disp_bcd, lap_num, disp_blank, state
    );

    modport slave (
        input  btn_ss, btn_lap, tick_100hz, time_bcd,
        output count_tick, count_clr, disp_bcd, lap_num, disp_blank, state
    );

endinterface

// File: rtl/bcd2_inc.sv
// rtl/bcd2_inc.sv - combinational two-digit BCD incrementer, 99 wraps to 00
//
// Ports:
//   d : two BCD digits in (ones digit in d[3:0])
//   q : d + 1 in BCD, wrapping from 8'h99 to 8'h00
module bcd2_inc (
    input  logic [7:0] d,
    output logic [7:0] q
);

    always_comb begin
        q = d;
        if (d[3:0] >= 4'd9) begin
            q[3:0] = 4'd0;
            if (d[7:4] >= 4'd9) begin
                q[7:4] = 4'd0;
            end else begin
                q[7:4] = d[7:4] + 4'd1;
            end
        end else begin
            q[3:0] = d[3:0] + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM: tick gating, chain clear, saturation, lap latch, display select
//
// Parameters:
//   DIGITS      : BCD digits in the time word (4*DIGITS must equal TIME_W)
//   BLINK_TICKS : 100 Hz ticks per display blink half-period in PAUSE
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   sw    : stopwatch_ctrl_if.slave, buttons/tick/time in, tick/clear/display out
// Build option:
//   STOPWATCH_BLINK_EN : when defined, the display blinks while paused;
//                        otherwise disp_blank is tied low and no blink counter exists.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int BLINK_TICKS = 50
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    // The saturation constant is a fixed 8-digit hh:mm:ss.cc value.
    if (4 * DIGITS != TIME_W || BLINK_TICKS < 1) begin : g_param_check
        $error("stopwatch_ctrl: DIGITS must be 8 and BLINK_TICKS at least 1");
    end

    sw_state_t         state_q;
    sw_state_t         state_d;
    logic              do_latch;
    logic              do_clear;
    logic              saturated;
    logic              count_clr_q;
    logic [TIME_W-1:0] lap_reg;
    logic [7:0]        lap_num_q;
    logic [7:0]        lap_num_inc;

    assign saturated = (sw.time_bcd == TIME_MAX);

    bcd2_inc u_lap_inc (
        .d (lap_num_q),
        .q (lap_num_inc)
    );

    // Next state. btn_ss always takes precedence; a simultaneous btn_lap is dropped.
    always_comb begin
        state_d  = state_q;
        do_latch = 1'b0;
        do_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sw.btn_ss) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_LAP: begin
                if (sw.btn_ss) begin
                    state_d = ST_PAUSE;
                end else if (saturated && sw.tick_100hz) begin
                    // Chain is stuck at 99:59:59.99; stop the clock.
                    state_d = ST_PAUSE;
                end else if (sw.btn_lap) begin
                    state_d  = ST_LAP;
                    do_latch = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (sw.btn_ss) begin
                    // Resuming a saturated chain would only re-pause; only clear recovers.
                    if (!saturated) begin
                        state_d = ST_RUN;
                    end
                end else if (sw.btn_lap) begin
                    state_d  = ST_IDLE;
                    do_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_clr_q <= 1'b0;
            lap_reg     <= '0;
            lap_num_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            count_clr_q <= do_clear;
            if (do_clear) begin
                lap_reg   <= '0;
                lap_num_q <= 8'h00;
            end else if (do_latch) begin
                lap_reg   <= sw.time_bcd;
                lap_num_q <= lap_num_inc;
            end
        end
    end

    // Gated from the registered state, so the tick on the IDLE->RUN edge is lost
    // and the tick on the RUN->PAUSE edge still reaches the chain.
    assign sw.count_tick = sw.tick_100hz && !saturated &&
                           (state_q == ST_RUN || state_q == ST_LAP);
    assign sw.count_clr  = count_clr_q;
    assign sw.disp_bcd   = (state_q == ST_LAP) ? lap_reg : sw.time_bcd;
    assign sw.lap_num    = lap_num_q;
    assign sw.state      = state_q;

`ifdef STOPWATCH_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic [BW-1:0] blink_cnt;
    logic          blank_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blank_q   <= 1'b0;
        end else if (state_d != ST_PAUSE) begin
            // Leaving (or not in) PAUSE: display steady, phase restarts on next pause.
            blink_cnt <= '0;
            blank_q   <= 1'b0;
        end else if (state_q == ST_PAUSE && sw.tick_100hz) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blank_q   <= ~blank_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign sw.disp_blank = blank_q;
`else
    assign sw.disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_BLINK_EN
    localparam int BT = 2;
`else
    localparam int BT = 50;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   ticks_seen;

    stopwatch_ctrl_if #(.DIGITS(8)) sw ();

    stopwatch_ctrl #(
        .DIGITS      (8),
        .BLINK_TICKS (BT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given button/tick inputs; count_tick is sampled
    // mid-cycle, registered outputs are sampled 1 ns after the rising edge.
    task automatic step(input logic ss, input logic lap, input logic tk);
        @(negedge clk);
        sw.btn_ss     = ss;
        sw.btn_lap    = lap;
        sw.tick_100hz = tk;
        #1;
        if (sw.count_tick === 1'b1) ticks_seen++;
        @(posedge clk);
        #1;
        sw.btn_ss     = 1'b0;
        sw.btn_lap    = 1'b0;
        sw.tick_100hz = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ticks_seen = 0;
        reset = 1'b0;
        sw.btn_ss = 1'b0;
        sw.btn_lap = 1'b0;
        sw.tick_100hz = 1'b0;
        sw.time_bcd = 32'h12345678;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        sw.tick_100hz = 1'b1;
        #1;
        chk("rst_tick", {31'd0, sw.count_tick}, 32'd0);
        chk("rst_state", {30'd0, sw.state}, 32'd0);
        chk("rst_clr", {31'd0, sw.count_clr}, 32'd0);
        chk("rst_lapnum", {24'd0, sw.lap_num}, 32'h00);
        chk("rst_blank", {31'd0, sw.disp_blank}, 32'd0);
        sw.tick_100hz = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // 1: idle ignores ticks
        ticks_seen = 0;
        repeat (20) step(1'b0, 1'b0, 1'b1);
        chk("idle_ticks", ticks_seen, 0);
        chk("idle_state", {30'd0, sw.state}, 32'd0);
        chk("idle_disp", sw.disp_bcd, 32'h12345678);
        chk("idle_lapnum", {24'd0, sw.lap_num}, 32'h00);
        step(1'b0, 1'b1, 1'b0);
        chk("idle_lap_ignored", {30'd0, sw.state}, 32'd0);

        // 2: start, coincident tick not counted, then 5 counted
        sw.time_bcd = 32'h00000000;
        ticks_seen = 0;
        step(1'b1, 1'b0, 1'b1);
        chk("start_edge_tick", ticks_seen, 0);
        chk("run_state", {30'd0, sw.state}, 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        chk("run_ticks", ticks_seen, 5);

        // 3: lap latch and re-latch
        sw.time_bcd = 32'h00001234;
        step(1'b0, 1'b1, 1'b0);
        chk("lap_state", {30'd0, sw.state}, 32'd3);
        chk("lap_num1", {24'd0, sw.lap_num}, 32'h01);
        sw.time_bcd = 32'h00001299;
        #1;
        chk("lap_disp_frozen", sw.disp_bcd, 32'h00001234);
        ticks_seen = 0;
        step(1'b0, 1'b0, 1'b1);
        chk("lap_counting", ticks_seen, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_num2", {24'd0, sw.lap_num}, 32'h02);
        sw.time_bcd = 32'h00001300;
        #1;
        chk("lap_relatch", sw.disp_bcd, 32'h00001299);

        // 4: pause then clear
        step(1'b1, 1'b0, 1'b0);
        chk("pause_state", {30'd0, sw.state}, 32'd2);
        chk("pause_disp", sw.disp_bcd, 32'h00001300);
        ticks_seen = 0;
        step(1'b0, 1'b0, 1'b1);
        chk("pause_no_tick", ticks_seen, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("clr_state", {30'd0, sw.state}, 32'd0);
        chk("clr_pulse", {31'd0, sw.count_clr}, 32'd1);
        chk("clr_lapnum", {24'd0, sw.lap_num}, 32'h00);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_pulse_end", {31'd0, sw.count_clr}, 32'd0);

        // 5: simultaneous buttons in RUN, tick on the pause edge is counted
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("resume_state", {30'd0, sw.state}, 32'd1);
        ticks_seen = 0;
        step(1'b1, 1'b1, 1'b1);
        chk("both_state", {30'd0, sw.state}, 32'd2);
        chk("both_lapnum", {24'd0, sw.lap_num}, 32'h01);
        chk("pause_edge_tick", ticks_seen, 1);
        chk("both_disp", sw.disp_bcd, 32'h00001300);

        // 6: saturation
        step(1'b1, 1'b0, 1'b0);
        sw.time_bcd = 32'h99595999;
        ticks_seen = 0;
        step(1'b0, 1'b0, 1'b1);
        chk("sat_no_tick", ticks_seen, 0);
        chk("sat_pause", {30'd0, sw.state}, 32'd2);
        step(1'b1, 1'b0, 1'b0);
        chk("sat_stay_pause", {30'd0, sw.state}, 32'd2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
`ifdef STOPWATCH_BLINK_EN
        chk("blink_on", {31'd0, sw.disp_blank}, 32'd1);
`else
        chk("blink_off", {31'd0, sw.disp_blank}, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("blink_back", {31'd0, sw.disp_blank}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_clear", {30'd0, sw.state}, 32'd0);
        chk("sat_clr_pulse", {31'd0, sw.count_clr}, 32'd1);
        sw.time_bcd = 32'h00000000;

        // Lap index wrap 99 -> 00
        step(1'b1, 1'b0, 1'b0);
        repeat (99) step(1'b0, 1'b1, 1'b0);
        chk("lap_99", {24'd0, sw.lap_num}, 32'h99);
        step(1'b0, 1'b1, 1'b0);
        chk("lap_wrap", {24'd0, sw.lap_num}, 32'h00);
        chk("lap_wrap_state", {30'd0, sw.state}, 32'd3);

        // Asynchronous reset mid-run kills the tick at once
        @(negedge clk);
        sw.tick_100hz = 1'b1;
        #1;
        chk("pre_rst_tick", {31'd0, sw.count_tick}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_tick", {31'd0, sw.count_tick}, 32'd0);
        chk("async_rst_state", {30'd0, sw.state}, 32'd0);
        sw.tick_100hz = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
